// File: rtl/radius_scale_pipe.sv
// Three-stage shift-add constant multiplier for the CORDIC radius correction.
// It has per-lane round-half-up and saturation, a bypass mode, and drain-before-switch reconfiguration.
module radius_scale_pipe #(
   parameter int WIDTH  = 16,
   parameter int LANES  = 2,
   parameter int NTERMS = 4,
   parameter int GUARD  = 4,
   parameter int SHW    = $clog2(WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_load,
   input  logic                   cfg_bypass,
   input  logic [NTERMS-1:0]      cfg_en,
   input  logic [NTERMS-1:0]      cfg_neg,
   input  logic [NTERMS*SHW-1:0]  cfg_shift,
   output logic                   cfg_busy,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_sat
);
   localparam int XW = WIDTH + GUARD;
   localparam int SW = WIDTH + GUARD + $clog2(NTERMS) + 1;
   localparam int CW = 1 + 2*NTERMS + NTERMS*SHW;
   localparam logic [CW-1:0] CFG_RST =
      {1'b0, NTERMS'(1'b1), {NTERMS{1'b0}}, {(NTERMS*SHW){1'b0}}};
   localparam logic signed [SW-1:0] HALF = SW'(1'b1) << (GUARD-1);
   localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

   logic [CW-1:0]          act_q, act_d, shd_q, shd_d, cfg_in_s;
   logic                   cfg_busy_q, cfg_busy_d;
   logic                   s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
   logic [LANES*XW-1:0]    s1_x_q, s1_x_d;
   logic [LANES*SW-1:0]    s2_sum_q, s2_sum_d;
   logic [LANES*WIDTH-1:0] s3_data_q, s3_data_d;
   logic [LANES-1:0]       s3_sat_q, s3_sat_d;
   logic                   act_bypass_s;
   logic [NTERMS-1:0]      act_en_s, act_neg_s;
   logic [NTERMS*SHW-1:0]  act_shift_s;
   logic                   stall_s, empty_s, accept_s;
   logic                   s1_free_s, s2_free_s, s3_free_s;
   logic signed [SW-1:0]   s2_xs_s, s2_acc_s, s2_term_s, s3_sum_s, s3_r_s;

   assign cfg_in_s = {cfg_bypass, cfg_en, cfg_neg, cfg_shift};
   assign {act_bypass_s, act_en_s, act_neg_s, act_shift_s} = act_q;

   // Handshake and stage occupancy; a stage moves on when its successor is empty or moving.
   always_comb begin
      stall_s   = s3_v_q & ~out_ready;
      empty_s   = ~(s1_v_q | s2_v_q | s3_v_q);
      s3_free_s = ~s3_v_q | out_ready;
      s2_free_s = ~s2_v_q | s3_free_s;
      s1_free_s = ~s1_v_q | s2_free_s;
      in_ready  = ~stall_s & ~cfg_busy_q & ~(cfg_load & empty_s);
      accept_s  = in_valid & in_ready;
      s1_v_d    = s1_free_s ? accept_s : s1_v_q;
      s2_v_d    = s2_free_s ? s1_v_q : s2_v_q;
      s3_v_d    = s3_free_s ? s2_v_q : s3_v_q;
   end

   // Config only changes while nothing is in flight, so a beat never needs its own copy.
   always_comb begin
      act_d      = act_q;
      shd_d      = shd_q;
      cfg_busy_d = cfg_busy_q;
      if (cfg_busy_q) begin
         if (empty_s) begin
            act_d      = cfg_load ? cfg_in_s : shd_q;
            cfg_busy_d = 1'b0;
         end else if (cfg_load) begin
            shd_d = cfg_in_s;
         end else begin
            shd_d = shd_q;
         end
      end else if (cfg_load) begin
         if (empty_s) begin
            act_d = cfg_in_s;
         end else begin
            shd_d      = cfg_in_s;
            cfg_busy_d = 1'b1;
         end
      end else begin
         act_d = act_q;
      end
   end

   // S1: capture each lane with GUARD fractional zero bits appended.
   always_comb begin
      s1_x_d = s1_x_q;
      if (accept_s) begin
         for (int j = 0; j < LANES; j++) begin
            s1_x_d[j*XW +: XW] = {in_data[j*WIDTH +: WIDTH], {GUARD{1'b0}}};
         end
      end else begin
         s1_x_d = s1_x_q;
      end
   end

   // S2: full-precision signed sum of the enabled shifted terms.
   always_comb begin
      s2_sum_d  = s2_sum_q;
      s2_xs_s   = {SW{1'b0}};
      s2_acc_s  = {SW{1'b0}};
      s2_term_s = {SW{1'b0}};
      if (s2_free_s && s1_v_q) begin
         for (int j = 0; j < LANES; j++) begin
            s2_xs_s  = {{(SW-XW){s1_x_q[j*XW+XW-1]}}, s1_x_q[j*XW +: XW]};
            s2_acc_s = {SW{1'b0}};
            if (act_bypass_s) begin
               s2_acc_s = s2_xs_s;
            end else begin
               for (int i = 0; i < NTERMS; i++) begin
                  s2_term_s = s2_xs_s >>> act_shift_s[i*SHW +: SHW];
                  if (act_en_s[i]) begin
                     s2_acc_s = act_neg_s[i] ? s2_acc_s - s2_term_s : s2_acc_s + s2_term_s;
                  end else begin
                     s2_acc_s = s2_acc_s;
                  end
               end
            end
            s2_sum_d[j*SW +: SW] = s2_acc_s;
         end
      end else begin
         s2_sum_d = s2_sum_q;
      end
   end

   // S3: drop guard bits with round-half-up, then clamp to the sample range.
   always_comb begin
      s3_data_d = s3_data_q;
      s3_sat_d  = s3_sat_q;
      s3_sum_s  = {SW{1'b0}};
      s3_r_s    = {SW{1'b0}};
      if (s3_free_s && s2_v_q) begin
         for (int j = 0; j < LANES; j++) begin
            s3_sum_s = s2_sum_q[j*SW +: SW];
            s3_r_s   = (s3_sum_s + HALF) >>> GUARD;
            if (s3_r_s > MAXV) begin
               s3_data_d[j*WIDTH +: WIDTH] = SAT_HI;
               s3_sat_d[j]                 = 1'b1;
            end else if (s3_r_s < MINV) begin
               s3_data_d[j*WIDTH +: WIDTH] = SAT_LO;
               s3_sat_d[j]                 = 1'b1;
            end else begin
               s3_data_d[j*WIDTH +: WIDTH] = s3_r_s[WIDTH-1:0];
               s3_sat_d[j]                 = 1'b0;
            end
         end
      end else begin
         s3_data_d = s3_data_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q      <= CFG_RST;
         shd_q      <= {CW{1'b0}};
         cfg_busy_q <= 1'b0;
         s1_v_q     <= 1'b0;
         s2_v_q     <= 1'b0;
         s3_v_q     <= 1'b0;
         s1_x_q     <= {(LANES*XW){1'b0}};
         s2_sum_q   <= {(LANES*SW){1'b0}};
         s3_data_q  <= {(LANES*WIDTH){1'b0}};
         s3_sat_q   <= {LANES{1'b0}};
      end else begin
         act_q      <= act_d;
         shd_q      <= shd_d;
         cfg_busy_q <= cfg_busy_d;
         s1_v_q     <= s1_v_d;
         s2_v_q     <= s2_v_d;
         s3_v_q     <= s3_v_d;
         s1_x_q     <= s1_x_d;
         s2_sum_q   <= s2_sum_d;
         s3_data_q  <= s3_data_d;
         s3_sat_q   <= s3_sat_d;
      end
   end

   assign cfg_busy  = cfg_busy_q;
   assign out_valid = s3_v_q;
   assign out_data  = s3_data_q;
   assign out_sat   = s3_sat_q;
endmodule

// File: tb/tb_radius_scale_pipe.sv
// Directed testbench for radius_scale_pipe with default parameters (16-bit, 2 lanes, 4 terms, 4 guard bits).
module tb_radius_scale_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_load, cfg_bypass, cfg_busy;
   logic [3:0]  cfg_en, cfg_neg;
   logic [15:0] cfg_shift;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [1:0]  out_sat;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   radius_scale_pipe dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_bypass(cfg_bypass),
      .cfg_en(cfg_en), .cfg_neg(cfg_neg), .cfg_shift(cfg_shift), .cfg_busy(cfg_busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
   );

   function automatic logic [31:0] pk(input int l0, input int l1);
      pk = {16'(l1), 16'(l0)};
   endfunction

   task automatic load_cfg(input logic byp, input logic [3:0] en, input logic [3:0] neg,
                           input logic [15:0] sh);
      cfg_bypass = byp; cfg_en = en; cfg_neg = neg; cfg_shift = sh; cfg_load = 1'b1;
      @(posedge clk); #1;
      cfg_load = 1'b0;
   endtask

   task automatic run_one(input int l0, input int l1, output logic [31:0] d,
                          output logic [1:0] s, output int lat);
      in_data = pk(l0, l1); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      d = out_data; s = out_sat;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cfg_load = 1'b0; cfg_bypass = 1'b0; cfg_en = 4'h0; cfg_neg = 4'h0;
      cfg_shift = 16'h0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
      checks++; if (out_sat !== 2'b00) begin failures++; $display("FAIL rst_out_sat got=%b exp=00", out_sat); end
      checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL rst_cfg_busy got=%b exp=0", cfg_busy); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_identity;
      logic [31:0] d; logic [1:0] s; int lat;
      run_one(1234, -5, d, s, lat);
      checks++; if (d !== pk(1234, -5)) begin failures++; $display("FAIL ident_data got=%h exp=%h", d, pk(1234, -5)); end
      checks++; if (s !== 2'b00) begin failures++; $display("FAIL ident_sat got=%b exp=00", s); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL ident_latency got=%0d exp=3", lat); end
   endtask

   task automatic test_onek;
      logic [31:0] d; logic [1:0] s; int lat;
      load_cfg(1'b0, 4'b1111, 4'b1100, 16'h9631);
      run_one(1000, -1000, d, s, lat);
      checks++; if (d !== pk(607, -607)) begin failures++; $display("FAIL onek_data got=%h exp=%h", d, pk(607, -607)); end
      checks++; if (s !== 2'b00) begin failures++; $display("FAIL onek_sat got=%b exp=00", s); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL onek_latency got=%0d exp=3", lat); end
   endtask

   task automatic test_rounding;
      logic [31:0] d; logic [1:0] s; int lat;
      load_cfg(1'b0, 4'b0001, 4'b0000, 16'h0001);
      run_one(3, -3, d, s, lat);
      checks++; if (d !== pk(2, -1)) begin failures++; $display("FAIL round_1p5 got=%h exp=%h", d, pk(2, -1)); end
      run_one(1, -1, d, s, lat);
      checks++; if (d !== pk(1, 0)) begin failures++; $display("FAIL round_0p5 got=%h exp=%h", d, pk(1, 0)); end
   endtask

   task automatic test_saturation;
      logic [31:0] d; logic [1:0] s; int lat;
      load_cfg(1'b0, 4'b0011, 4'b0000, 16'h0000);
      run_one(20000, -20000, d, s, lat);
      checks++; if (d !== pk(32767, -32768)) begin failures++; $display("FAIL sat_data got=%h exp=%h", d, pk(32767, -32768)); end
      checks++; if (s !== 2'b11) begin failures++; $display("FAIL sat_flags got=%b exp=11", s); end
      run_one(16384, -16384, d, s, lat);
      checks++; if (d !== pk(32767, -32768)) begin failures++; $display("FAIL sat_edge_data got=%h exp=%h", d, pk(32767, -32768)); end
      checks++; if (s !== 2'b01) begin failures++; $display("FAIL sat_edge_flags got=%b exp=01", s); end
      run_one(16383, -16383, d, s, lat);
      checks++; if (d !== pk(32766, -32766) || s !== 2'b00) begin
         failures++; $display("FAIL sat_inrange got=%h/%b exp=%h/00", d, s, pk(32766, -32766));
      end
   endtask

   task automatic test_cfg_wins;
      logic [31:0] d; logic [1:0] s; int lat; logic seen;
      cfg_bypass = 1'b0; cfg_en = 4'b0000; cfg_neg = 4'b0000; cfg_shift = 16'h0;
      cfg_load = 1'b1; in_valid = 1'b1; in_data = pk(1234, -5);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cfgwin_in_ready got=%b exp=0", in_ready); end
      @(posedge clk); #1;
      cfg_load = 1'b0; in_valid = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL cfgwin_no_beat got=%b exp=0", seen); end
      run_one(1234, -5, d, s, lat);
      checks++; if (d !== 32'h0 || s !== 2'b00) begin failures++; $display("FAIL noterms got=%h/%b exp=0/00", d, s); end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_q [6];
      int sent, recv, stalls;
      load_cfg(1'b0, 4'b0001, 4'b0000, 16'h0000);
      for (int k = 0; k < 6; k++) exp_q[k] = pk(k*1000 + 3, -(k*1000) - 3);
      sent = 0; recv = 0; stalls = 0;
      for (int c = 0; c < 40; c++) begin
         out_ready = !(c >= 4 && c < 9);
         in_valid  = (sent < 6);
         in_data   = exp_q[sent % 6];
         #1;
         if (out_valid === 1'b1 && out_ready === 1'b0) begin
            stalls++;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
            checks++; if (recv >= 6 || out_data !== exp_q[recv % 6]) begin
               failures++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, out_data, exp_q[recv % 6]);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++; if (recv >= 6 || out_data !== exp_q[recv % 6]) begin
               failures++; $display("FAIL bp_order beat=%0d got=%h exp=%h", recv, out_data, exp_q[recv % 6]);
            end
            recv++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      out_ready = 1'b1; in_valid = 1'b0;
      checks++; if (sent !== 6) begin failures++; $display("FAIL bp_sent got=%0d exp=6", sent); end
      checks++; if (recv !== 6) begin failures++; $display("FAIL bp_recv got=%0d exp=6", recv); end
      checks++; if (stalls !== 5) begin failures++; $display("FAIL bp_stalls got=%0d exp=5", stalls); end
   endtask

   task automatic test_reconfig;
      logic [31:0] exp_q [3];
      int recv, busy_cnt; logic sent_c;
      load_cfg(1'b0, 4'b1111, 4'b1100, 16'h9631);
      exp_q[0] = pk(607, -607); exp_q[1] = pk(-607, 607); exp_q[2] = pk(500, -32768);
      recv = 0; busy_cnt = 0; sent_c = 1'b0;
      for (int c = 0; c < 40; c++) begin
         cfg_load = (c == 2);
         if (c == 2) begin cfg_bypass = 1'b1; cfg_en = 4'b0000; cfg_neg = 4'b0000; cfg_shift = 16'h0; end
         in_valid = (c == 0) || (c == 1) || (c >= 3 && !sent_c);
         in_data  = (c == 0) ? pk(1000, -1000) : (c == 1) ? pk(-1000, 1000) : pk(500, -32768);
         #1;
         if (c == 3) begin
            checks++; if (cfg_busy !== 1'b1) begin failures++; $display("FAIL rc_busy_set got=%b exp=1", cfg_busy); end
         end
         if (cfg_busy === 1'b1) begin
            busy_cnt++;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rc_in_ready c=%0d got=%b exp=0", c, in_ready); end
         end
         if (out_valid === 1'b1) begin
            checks++; if (recv >= 3 || out_data !== exp_q[recv % 3]) begin
               failures++; $display("FAIL rc_data beat=%0d got=%h exp=%h", recv, out_data, exp_q[recv % 3]);
            end
            recv++;
         end
         if (c >= 3 && in_valid && in_ready) sent_c = 1'b1;
         @(posedge clk); #1;
      end
      cfg_load = 1'b0; in_valid = 1'b0;
      checks++; if (recv !== 3) begin failures++; $display("FAIL rc_recv got=%0d exp=3", recv); end
      checks++; if (busy_cnt !== 3) begin failures++; $display("FAIL rc_busy_cycles got=%0d exp=3", busy_cnt); end
   endtask

   task automatic test_reset_midstream;
      logic [31:0] d; logic [1:0] s; int lat; logic stale;
      load_cfg(1'b0, 4'b1111, 4'b1100, 16'h9631);
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; in_data = pk(1000 + c, -1000);
         cfg_load = (c == 2);
         cfg_bypass = 1'b0; cfg_en = 4'b0011; cfg_neg = 4'b0000; cfg_shift = 16'h0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; cfg_load = 1'b0;
      #1;
      checks++; if (cfg_busy !== 1'b1 || out_valid !== 1'b1) begin
         failures++; $display("FAIL rm_pre busy=%b valid=%b exp=1/1", cfg_busy, out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
      checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", cfg_busy); end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (6) begin
         if (out_valid !== 1'b0) stale = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (stale !== 1'b0) begin failures++; $display("FAIL rm_stale got=%b exp=0", stale); end
      run_one(1000, -1000, d, s, lat);
      checks++; if (d !== pk(1000, -1000) || s !== 2'b00) begin
         failures++; $display("FAIL rm_identity got=%h/%b exp=%h/00", d, s, pk(1000, -1000));
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_onek();
      test_rounding();
      test_saturation();
      test_cfg_wins();
      test_backpressure();
      test_reconfig();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
